puf_challenge_sequencer: RTL and testbench
==========================================

# puf_challenge_sequencer

Sequences one 32-stage arbiter PUF built from the team's mux2x1 stages. On a start request, the block does the following for each response bit:
- loads a challenge onto the stage selects;
- clears the arbiter latch and fires a launch edge down both paths;
- waits for the race to settle, then samples the synchronised arbiter output;
- repeats the evaluation VOTE times and keeps the majority result.

Challenges come from a 32-bit LFSR seeded by the host. The block sits between the host/register interface and the PUF fabric.

## Interface
- N_RESP, 16, response bits per run (1..32)
- VOTE, 3, evaluations per challenge; odd, 1..15
- SETTLE_CYC, 8, cycles waited after launch before sampling; >= 2, covers the 2-flop synchroniser
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  run request; sampled only in IDLE
- SEED  in  32  initial challenge; 0 is replaced by 32'h0000_0001
- ARB_OUT  in  1  asynchronous arbiter latch output (1 = top path won)
- CHAL  out  32  stage selects S[31:0] to the mux chain
- ARB_CLR  out  1  clears the arbiter latch while high
- LAUNCH  out  1  race launch edge into both chain inputs
- RESP  out  N_RESP  response shift register
- BUSY  out  1  high from the cycle after START acceptance through the last NEXT
- DONE  out  1  one-cycle pulse when RESP is final

## Operation
- States:
  - IDLE
  - CLEAR: ARB_CLR=1, 1 cycle
  - FIRE: LAUNCH=1, 1 cycle
  - SETTLE: SETTLE_CYC cycles
  - SAMPLE: 1 cycle
  - NEXT: 1 cycle
  - FIN: DONE=1, 1 cycle
- IDLE, START=1 → CLEAR. On entry:
  - CHAL <= (SEED==0 ? 1 : SEED);
  - RESP <= 0, bit_cnt <= 0, eval_cnt <= 0, ones <= 0.
- CLEAR → FIRE → SETTLE → SAMPLE.
- SAMPLE: ones <= ones + arb_sync, eval_cnt++.
  - eval_cnt+1 < VOTE → CLEAR.
  - Otherwise → NEXT.
- NEXT:
  - RESP <= {RESP[N_RESP-2:0], (ones > VOTE/2)}, so the first bit ends in the MSB.
  - CHAL <= {CHAL[30:0], CHAL[31]^CHAL[21]^CHAL[1]^CHAL[0]} (x^32+x^22+x^2+x+1).
  - ones <= 0, eval_cnt <= 0, bit_cnt++.
  - bit_cnt+1 == N_RESP → FIN; otherwise → CLEAR.
- FIN → IDLE. RESP holds until the next START acceptance.
- CHAL is stable for the whole evaluation of a bit and changes only in NEXT.
- START outside IDLE is ignored; no queueing.
- ones width: $clog2(VOTE+1).
- bit_cnt width: $clog2(N_RESP+1).

## Timing
- Reset values: CHAL=0, ARB_CLR=0, LAUNCH=0, RESP=0, BUSY=0, DONE=0, state=IDLE, counters=0, synchroniser flops=0.
- RST mid-run: all state returns to reset values on the next edge. No DONE pulse; a partial RESP is discarded.
- RST has priority over START in the same cycle.
- Cycle numbering: START accepted in cycle 0.
  - CLEAR is cycle 1, FIRE is cycle 2, SETTLE is cycles 3..2+SETTLE_CYC, SAMPLE is cycle 3+SETTLE_CYC.
  - Evaluation length E = SETTLE_CYC+3.
  - Bit period = VOTE*E + 1.
  - DONE asserted in cycle N_RESP*(VOTE*E+1) + 1. Defaults give cycle 545.
- BUSY rises in cycle 1 and falls in the FIN cycle.
- START in the FIN cycle is ignored. The earliest restart is the cycle after DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package puf_pkg:
  - CHAL_W=32;
  - LFSR tap constant 32'h8020_0003;
  - state enum (IDLE, CLEAR, FIRE, SETTLE, SAMPLE, NEXT, FIN).
- Sub-module puf_sync2: a 2-flop synchroniser for ARB_OUT with reset to 0. Instantiated once; output is arb_sync.
- Single FSM plus counters; SETTLE reuses a down-counter loaded in FIRE.

## Test plan
- Reset then idle: RST=1 for 3 cycles → all outputs 0. START held while RST=1 → no run.
- Single bit, minimal run: N_RESP=1, VOTE=1, SETTLE_CYC=2, SEED=32'h1, ARB_OUT=1 → ARB_CLR in cycle 1, LAUNCH in cycle 2, DONE in cycle 7, RESP=1'b1.
- Defaults, SEED=32'hACE1_0001:
  - Model drives ARB_OUT = CHAL[0]^CHAL[31] → RESP matches the reference-model 16-bit value and DONE lands in cycle 545.
  - CHAL after the first NEXT equals 32'h59C2_0003.
- Majority vote: VOTE=3, ARB_OUT per evaluation 1,0,1 → bit=1; 0,1,0 → bit=0; 0,0,1 → bit=0.
- SEED=0 → CHAL=32'h1 in cycle 1. START pulses while BUSY do not restart the run (counters and DONE timing unchanged).
- RST asserted in cycle 100 of a default run → next cycle all outputs 0 and no DONE. A new START then completes normally with DONE 545 cycles later.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
package puf_pkg;

    localparam int CHAL_W = 32;
    localparam logic [CHAL_W-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FIRE,
        SETTLE,
        SAMPLE,
        NEXT,
        FIN
    } state_e;

    // Galois-free Fibonacci step: x^32 + x^22 + x^2 + x + 1
    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_sync2.sv
// Two-flop synchroniser bringing the asynchronous arbiter latch into CLK.
module puf_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives one 32-stage arbiter PUF: LFSR challenges, launch/settle/sample,
// majority vote per challenge, response bits shifted in MSB-first.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int N_RESP     = 16,
    parameter int VOTE       = 3,
    parameter int SETTLE_CYC = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [CHAL_W-1:0] SEED,
    input  logic              ARB_OUT,
    output logic [CHAL_W-1:0] CHAL,
    output logic              ARB_CLR,
    output logic              LAUNCH,
    output logic [N_RESP-1:0] RESP,
    output logic              BUSY,
    output logic              DONE
);

    localparam int OW = $clog2(VOTE + 1);
    localparam int EW = $clog2(VOTE + 1);
    localparam int BW = $clog2(N_RESP + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_e            state_q;
    logic [CHAL_W-1:0] chal_q;
    logic [N_RESP-1:0] resp_q;
    logic [OW-1:0]     ones_q;
    logic [EW-1:0]     eval_q;
    logic [BW-1:0]     bit_q;
    logic [SW-1:0]     settle_q;
    logic              clr_q;
    logic              launch_q;
    logic              busy_q;
    logic              done_q;

    logic              arb_sync;
    logic              vote_bit;
    logic [N_RESP-1:0] resp_d;

    puf_sync2 u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (ARB_OUT),
        .q_o   (arb_sync)
    );

    assign vote_bit = (ones_q > OW'(VOTE / 2));

    if (N_RESP == 1) begin : g_one
        assign resp_d = vote_bit;
    end else begin : g_many
        assign resp_d = {resp_q[N_RESP-2:0], vote_bit};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            chal_q   <= '0;
            resp_q   <= '0;
            ones_q   <= '0;
            eval_q   <= '0;
            bit_q    <= '0;
            settle_q <= '0;
            clr_q    <= 1'b0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            clr_q    <= 1'b0;
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        chal_q  <= (SEED == '0) ? {{(CHAL_W-1){1'b0}}, 1'b1} : SEED;
                        resp_q  <= '0;
                        ones_q  <= '0;
                        eval_q  <= '0;
                        bit_q   <= '0;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    launch_q <= 1'b1;
                    state_q  <= FIRE;
                end
                FIRE: begin
                    settle_q <= SW'(SETTLE_CYC - 1);
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    ones_q <= ones_q + OW'(arb_sync);
                    eval_q <= eval_q + 1'b1;
                    if (int'(eval_q) + 1 < VOTE) begin
                        clr_q   <= 1'b1;
                        state_q <= CLEAR;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    resp_q <= resp_d;
                    chal_q <= lfsr_next(chal_q);
                    ones_q <= '0;
                    eval_q <= '0;
                    bit_q  <= bit_q + 1'b1;
                    if (int'(bit_q) + 1 == N_RESP) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        clr_q   <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CHAL    = chal_q;
    assign ARB_CLR = clr_q;
    assign LAUNCH  = launch_q;
    assign RESP    = resp_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed self-checking bench for puf_challenge_sequencer.
module tb_puf_challenge_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] seed;
    logic        arb;
    logic        arb_man;
    logic        model_en;
    logic [31:0] chal;
    logic        clr;
    logic        launch;
    logic [15:0] resp;
    logic        busy;
    logic        done;

    logic        start_m;
    logic [31:0] seed_m;
    logic        arb_m;
    logic [31:0] chal_m;
    logic        clr_m;
    logic        launch_m;
    logic [0:0]  resp_m;
    logic        busy_m;
    logic        done_m;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    // PUF model: response bit follows the challenge
    assign arb = model_en ? (chal[0] ^ chal[31]) : arb_man;

    puf_challenge_sequencer dut (
        .CLK(clk), .RST(rst), .START(start), .SEED(seed), .ARB_OUT(arb),
        .CHAL(chal), .ARB_CLR(clr), .LAUNCH(launch), .RESP(resp),
        .BUSY(busy), .DONE(done)
    );

    puf_challenge_sequencer #(.N_RESP(1), .VOTE(1), .SETTLE_CYC(2)) dut_min (
        .CLK(clk), .RST(rst), .START(start_m), .SEED(seed_m), .ARB_OUT(arb_m),
        .CHAL(chal_m), .ARB_CLR(clr_m), .LAUNCH(launch_m), .RESP(resp_m),
        .BUSY(busy_m), .DONE(done_m)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    initial begin
        logic [31:0] c;
        logic [31:0] first_chal;
        logic [15:0] exp_resp;
        logic [8:0]  pat;
        int          first_at;
        int          done_at;
        int          busy_at_done;
        int          g;
        int          ndone;
        int          nbusy;

        rst = 1'b1; start = 1'b1; seed = 32'h0; arb_man = 1'b0; model_en = 1'b0;
        start_m = 1'b1; seed_m = 32'h1; arb_m = 1'b1;

        // reset with START held
        repeat (3) tick();
        chk("rst_chal", chal, 32'h0);
        chk("rst_ctl", {clr, launch, busy, done}, 4'b0);
        chk("rst_resp", resp, 16'h0);
        chk("rst_min", {chal_m, clr_m, launch_m, resp_m, busy_m, done_m}, 0);
        rst = 1'b0; start = 1'b0; start_m = 1'b0;
        tick(); tick();
        chk("no_run_after_rst", {busy, clr, busy_m, clr_m}, 4'b0);

        // minimal single-bit run
        start_m = 1'b1; cyc = 0;
        tick(); start_m = 1'b0;
        chk("min_c1", {clr_m, launch_m, busy_m}, 3'b101);
        chk("min_c1_chal", chal_m, 32'h1);
        tick();
        chk("min_c2", {clr_m, launch_m}, 2'b01);
        done_at = -1; busy_at_done = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            tick();
            if (done_m) begin done_at = cyc; busy_at_done = int'(busy_m); end
        end
        chk("min_done_cyc", done_at, 7);
        chk("min_resp", resp_m, 1'b1);
        chk("min_busy_fin", busy_at_done, 0);

        // default run, model-driven ARB_OUT, START pulse while busy
        seed = 32'hACE1_0001; model_en = 1'b1;
        c = seed; exp_resp = '0;
        for (int i = 0; i < 16; i++) begin
            exp_resp = {exp_resp[14:0], c[0] ^ c[31]};
            c = lfsr(c);
        end
        tick();
        start = 1'b1; cyc = 0;
        tick(); start = 1'b0;
        chk("def_c1_chal", chal, 32'hACE1_0001);
        first_at = -1; first_chal = '0; done_at = -1; busy_at_done = -1;
        while (done_at < 0 && cyc < 700) begin
            tick();
            start = (cyc == 50);
            if (first_at < 0 && chal !== 32'hACE1_0001) begin
                first_at = cyc; first_chal = chal;
            end
            if (done) begin done_at = cyc; busy_at_done = int'(busy); end
        end
        start = 1'b0;
        chal_chk: chk("def_first_next", first_chal, 32'h59C2_0003);
        chk("def_first_next_cyc", first_at, 35);
        chk("def_done_cyc", done_at, 545);
        chk("def_resp", resp, exp_resp);
        chk("def_busy_fin", busy_at_done, 0);
        tick();
        chk("def_done_pulse", {done, busy}, 2'b00);
        chk("def_resp_hold", resp, exp_resp);

        // SEED=0 run, then reset at cycle 100
        model_en = 1'b0; arb_man = 1'b1; seed = 32'h0;
        tick();
        start = 1'b1; cyc = 0;
        tick(); start = 1'b0;
        chk("seed0_chal", chal, 32'h1);
        while (cyc < 100) tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("midrst_chal", chal, 32'h0);
        chk("midrst_ctl", {clr, launch, busy, done}, 4'b0);
        chk("midrst_resp", resp, 16'h0);
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done) ndone++;
            if (busy) nbusy++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_no_busy", nbusy, 0);

        // majority vote: 1,0,1 / 0,1,0 / 0,0,1 then zeros
        pat = 9'b100_010_101; seed = 32'h1234_5678; arb_man = 1'b0;
        start = 1'b1; cyc = 0;
        tick(); start = 1'b0;
        for (int e = 0; e < 10; e++) begin
            g = 0;
            while (clr !== 1'b1 && g < 100) begin tick(); g++; end
            chk("maj_clr_wait", int'(g < 100), 1);
            arb_man = (e < 9) ? pat[e] : 1'b0;
            if (e == 3) chk("maj_bit0", resp, 16'h1);
            if (e == 6) chk("maj_bit1", resp, 16'h2);
            if (e == 9) chk("maj_bit2", resp, 16'h4);
            tick();
        end
        done_at = -1;
        while (done_at < 0 && cyc < 700) begin
            tick();
            if (done) done_at = cyc;
        end
        chk("maj_done_cyc", done_at, 545);
        chk("maj_resp", resp, 16'h8000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
